// File: rtl/coin_count.sv
// Coin-operated vending balance counter: synchronized, edge-detected request
// inputs drive a single prioritized balance update per clock.
`timescale 1ns/1ps

module coin_count #(
   parameter int unsigned PRICE_ONE = 5,
   parameter int unsigned PRICE_TWO = 3,
   parameter int unsigned MAX_VAL   = 999
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_one,
   input  logic       coin_ten,
   input  logic       buy_one,
   input  logic       buy_two,
   input  logic       get_ind,
   input  logic       cancle_flag,
   output logic [9:0] coin_val,
   output logic       buy_flag
);

   localparam int REQ_N = 6;

   // Bit positions of each request inside the packed request vectors.
   localparam int IDX_COIN_ONE = 0;
   localparam int IDX_COIN_TEN = 1;
   localparam int IDX_BUY_TWO  = 2;
   localparam int IDX_BUY_ONE  = 3;
   localparam int IDX_GET      = 4;
   localparam int IDX_CANCEL   = 5;

   localparam logic [9:0]  PRICE_ONE_W = 10'(PRICE_ONE);
   localparam logic [9:0]  PRICE_TWO_W = 10'(PRICE_TWO);
   localparam logic [10:0] MAX_VAL_W   = 11'(MAX_VAL);

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_CLEAR,
      ACT_BUY_ONE,
      ACT_BUY_TWO,
      ACT_COIN_TEN,
      ACT_COIN_ONE
   } action_t;

   logic [REQ_N-1:0] req_raw;
   logic [REQ_N-1:0] sync_q1;
   logic [REQ_N-1:0] sync_q2;
   logic [REQ_N-1:0] prev_q;
   logic [REQ_N-1:0] armed_q;
   logic [REQ_N-1:0] req_event;
   logic [1:0]       fill_q;
   logic             fill_done;

   action_t          action;
   logic [9:0]       next_val;
   logic             next_flag;

   assign req_raw = {cancle_flag, get_ind, buy_one, buy_two, coin_ten, coin_one};

   // fill_done marks that sync_q2 now holds a genuine post-reset sample rather
   // than the reset value; only then may a low level arm the edge detector.
   assign fill_done = (fill_q == 2'd2);

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge value of its source; blocking here would collapse the sync chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
         prev_q  <= '0;
         armed_q <= '0;
         fill_q  <= '0;
      end else begin
         sync_q1 <= req_raw;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
         if (!fill_done) begin
            fill_q <= fill_q + 2'd1;
         end else begin
            armed_q <= armed_q | ~sync_q2;
         end
      end
   end

   // An input held high across reset release never arms, so it cannot
   // produce an event until it has been seen low and then rises again.
   assign req_event = sync_q2 & ~prev_q & armed_q;

   // NOTE: every always_comb output gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      action = ACT_NONE;
      if (req_event[IDX_CANCEL] || req_event[IDX_GET]) begin
         action = ACT_CLEAR;
      end else if (req_event[IDX_BUY_ONE]) begin
         action = ACT_BUY_ONE;
      end else if (req_event[IDX_BUY_TWO]) begin
         action = ACT_BUY_TWO;
      end else if (req_event[IDX_COIN_TEN]) begin
         action = ACT_COIN_TEN;
      end else if (req_event[IDX_COIN_ONE]) begin
         action = ACT_COIN_ONE;
      end
   end

   // A failed purchase still wins the slot: lower-priority events that clock are dropped.
   always_comb begin
      next_val  = coin_val;
      next_flag = 1'b0;
      case (action)
         ACT_CLEAR: begin
            next_val = '0;
         end
         ACT_BUY_ONE: begin
            if (coin_val >= PRICE_ONE_W) begin
               next_val  = coin_val - PRICE_ONE_W;
               next_flag = 1'b1;
            end
         end
         ACT_BUY_TWO: begin
            if (coin_val >= PRICE_TWO_W) begin
               next_val  = coin_val - PRICE_TWO_W;
               next_flag = 1'b1;
            end
         end
         ACT_COIN_TEN: begin
            if (({1'b0, coin_val} + 11'd10) <= MAX_VAL_W) begin
               next_val = coin_val + 10'd10;
            end
         end
         ACT_COIN_ONE: begin
            if (({1'b0, coin_val} + 11'd1) <= MAX_VAL_W) begin
               next_val = coin_val + 10'd1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coin_val <= '0;
         buy_flag <= 1'b0;
      end else begin
         coin_val <= next_val;
         buy_flag <= next_flag;
      end
   end

endmodule

// File: tb/tb_coin_count.sv
// Directed self-checking bench for coin_count: coins, purchases, clearing,
// ceiling saturation, held inputs, latency and asynchronous reset.
`timescale 1ns/1ps

module tb_coin_count;

   logic       clk;
   logic       reset;
   logic [5:0] req;
   logic [9:0] coin_val;
   logic       buy_flag;

   int checks;
   int errors;
   int flag_cycles;

   localparam int C_ONE  = 0;
   localparam int C_TEN  = 1;
   localparam int B_TWO  = 2;
   localparam int B_ONE  = 3;
   localparam int G_IND  = 4;
   localparam int CANCEL = 5;

   coin_count #(
      .PRICE_ONE(5),
      .PRICE_TWO(3),
      .MAX_VAL  (999)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .coin_one   (req[C_ONE]),
      .coin_ten   (req[C_TEN]),
      .buy_one    (req[B_ONE]),
      .buy_two    (req[B_TWO]),
      .get_ind    (req[G_IND]),
      .cancle_flag(req[CANCEL]),
      .coin_val   (coin_val),
      .buy_flag   (buy_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts clocks in which buy_flag is high, sampled away from the rising edge.
   always @(negedge clk) begin
      if (buy_flag === 1'b1) flag_cycles <= flag_cycles + 1;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; raises one request for `hold` clocks, then lets it settle.
   task automatic press(input int idx, input int hold);
      req[idx] = 1'b1;
      repeat (hold) @(negedge clk);
      req[idx] = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int f0;
      checks      = 0;
      errors      = 0;
      flag_cycles = 0;
      req         = '0;
      reset       = 1'b0;

      // Reset state, with coin_ten already high across release.
      req[C_TEN] = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_val", 32'(coin_val), 0);
      check("reset_flag", 32'(buy_flag), 0);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check("held_at_release", 32'(coin_val), 0);
      req[C_TEN] = 1'b0;
      repeat (5) @(negedge clk);
      check("held_at_release_drop", 32'(coin_val), 0);

      // Latency: update on the third rising edge that samples the input high.
      req[C_ONE] = 1'b1;
      @(negedge clk);
      req[C_ONE] = 1'b0;
      check("latency_edge1", 32'(coin_val), 0);
      @(negedge clk);
      check("latency_edge2", 32'(coin_val), 0);
      @(negedge clk);
      check("latency_edge3", 32'(coin_val), 1);
      repeat (4) @(negedge clk);

      press(C_ONE, 1);
      check("coin_one_2", 32'(coin_val), 2);
      press(C_ONE, 1);
      check("coin_one_3", 32'(coin_val), 3);
      press(C_TEN, 1);
      check("coin_ten_13", 32'(coin_val), 13);
      check("no_flag_coins", 32'(flag_cycles), 0);

      // Purchases from 13.
      press(B_TWO, 1);
      check("buy_two_10", 32'(coin_val), 10);
      check("buy_two_pulse1", 32'(flag_cycles), 1);
      press(B_TWO, 2);
      check("buy_two_7", 32'(coin_val), 7);
      check("buy_two_pulse2", 32'(flag_cycles), 2);
      press(B_ONE, 1);
      check("buy_one_2", 32'(coin_val), 2);
      check("buy_one_pulse", 32'(flag_cycles), 3);

      // Insufficient funds.
      press(B_ONE, 1);
      check("buy_one_short", 32'(coin_val), 2);
      check("buy_one_short_flag", 32'(flag_cycles), 3);

      // Clearing.
      press(G_IND, 1);
      check("get_ind_0", 32'(coin_val), 0);
      press(C_TEN, 1);
      check("coin_ten_10", 32'(coin_val), 10);
      press(CANCEL, 1);
      check("cancel_0", 32'(coin_val), 0);

      // Ceiling: 99 tens and 5 ones reach 995.
      for (int i = 0; i < 99; i++) press(C_TEN, 1);
      for (int i = 0; i < 5; i++) press(C_ONE, 1);
      check("reach_995", 32'(coin_val), 995);
      press(C_TEN, 1);
      check("ten_rejected", 32'(coin_val), 995);
      for (int i = 0; i < 4; i++) press(C_ONE, 1);
      check("reach_999", 32'(coin_val), 999);
      press(C_ONE, 1);
      check("one_rejected", 32'(coin_val), 999);

      // Held high 20 clocks counts once.
      press(CANCEL, 1);
      check("cancel_from_999", 32'(coin_val), 0);
      press(C_ONE, 20);
      check("held_once", 32'(coin_val), 1);

      // Asynchronous reset between clock edges.
      press(CANCEL, 1);
      press(C_TEN, 1);
      check("pre_async_10", 32'(coin_val), 10);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_val", 32'(coin_val), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);

      // Reset mid-flight discards the event pending in the synchronizer.
      req[C_ONE] = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      req[C_ONE] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check("pending_discarded", 32'(coin_val), 0);

      // Simultaneous buy_two + coin_ten at 10: only the purchase applies.
      press(C_TEN, 1);
      check("pre_simul_10", 32'(coin_val), 10);
      f0 = flag_cycles;
      req[B_TWO] = 1'b1;
      req[C_TEN] = 1'b1;
      @(negedge clk);
      req = '0;
      repeat (5) @(negedge clk);
      check("simul_7", 32'(coin_val), 7);
      check("simul_pulse", 32'(flag_cycles - f0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coin_count.md
COIN_COUNT -- requirements
Module: coin_count

Interface
REQ-001 Parameter PRICE_ONE, default 5, price of item 1 in units.
REQ-002 Parameter PRICE_TWO, default 3, price of item 2 in units.
REQ-003 Parameter MAX_VAL, default 999, balance ceiling in units.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, system clock; all state updates on rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-007 Port coin_one, input, 1, 1-unit coin inserted; asynchronous level, event on rising edge.
REQ-008 Port coin_ten, input, 1, 10-unit coin inserted; asynchronous level, event on rising edge.
REQ-009 Port buy_one, input, 1, purchase request for item 1; asynchronous level, event on rising edge.
REQ-010 Port buy_two, input, 1, purchase request for item 2; asynchronous level, event on rising edge.
REQ-011 Port get_ind, input, 1, take-change request; asynchronous level, event on rising edge.
REQ-012 Port cancle_flag, input, 1, cancel/refund request; asynchronous level, event on rising edge.
REQ-013 Port coin_val, output, 10, current balance, unsigned binary, registered.
REQ-014 Port buy_flag, output, 1, successful-purchase indicator, registered.

Function
REQ-015 Each of the six request inputs SHALL pass through a 2-flop synchronizer, then a rising-edge detector.
  - The detector yields a one-clk event pulse per 0->1 transition.
  - Held-high levels SHALL NOT repeat events.
REQ-016 Latency: coin_val/buy_flag SHALL update on the 3rd rising clk edge at which the raw input is sampled high.
REQ-017 coin_one event: balance += 1 if balance+1 <= MAX_VAL, else balance unchanged.
REQ-018 coin_ten event: balance += 10 if balance+10 <= MAX_VAL, else balance unchanged (coin rejected, no partial credit).
REQ-019 buy_one event, balance >= PRICE_ONE: balance -= PRICE_ONE, buy_flag = 1 for exactly one clk.
REQ-020 buy_one event, balance < PRICE_ONE: balance unchanged, buy_flag stays 0.
REQ-021 buy_two: same as REQ-019/020 using PRICE_TWO.
REQ-022 get_ind event: balance SHALL become 0 (change dispensed).
REQ-023 cancle_flag event: balance SHALL become 0 (refund).
REQ-024 Simultaneous events in one clk: exactly one is applied, by fixed priority; the others are dropped.
  - Priority: cancle_flag > get_ind > buy_one > buy_two > coin_ten > coin_one.
REQ-025 buy_flag SHALL be 0 in every clk without a successful purchase.
REQ-026 Arithmetic: 10-bit unsigned; balance SHALL never underflow below 0 or exceed MAX_VAL.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force:
  - coin_val=0, buy_flag=0;
  - all synchronizer and edge-detector flops to 0.
REQ-028 While reset=0, all inputs SHALL be ignored.
REQ-029 Reset release: no event from inputs already high at release.
  - Since detector flops reset to 0, such inputs are only counted after a fresh 0->1 transition once synchronized.
REQ-030 Reset asserted mid-operation SHALL discard any pending (in-synchronizer) event.

Verification
REQ-031 Coins: reset, then coin_one x3, coin_ten x1 -> coin_val 1,2,3,13; buy_flag 0 throughout.
REQ-032 Purchases from 13: buy_two, buy_two, buy_one -> coin_val 10,7,2; one single-clk buy_flag pulse each.
REQ-033 Insufficient funds at 2: buy_one -> coin_val stays 2, no buy_flag pulse.
REQ-034 Clearing:
  - At 2, get_ind -> coin_val 0.
  - Then coin_ten -> 10; cancle_flag -> 0.
REQ-035 Ceiling:
  - Reach 995, coin_ten -> stays 995; coin_one x4 -> 999; coin_one -> stays 999.
  - coin_one held high 20 clks -> counts once.
REQ-036 Async reset:
  - At 10, reset=0 between clk edges -> coin_val 0 immediately.
  - Simultaneous buy_two+coin_ten at 10 -> 7 only.
